// File: rtl/pmem_burst_pkg.sv
// Shared types and default geometry for the cache-line to DRAM burst adaptor.
package pmem_burst_pkg;

   localparam int unsigned PMEM_LINE_W = 256;
   localparam int unsigned PMEM_BEAT_W = 64;
   localparam int unsigned PMEM_BEATS  = PMEM_LINE_W / PMEM_BEAT_W;

   typedef logic [$clog2(PMEM_BEATS)-1:0] beat_idx_t;

   typedef enum logic [1:0] {
      IDLE,
      RD_BURST,
      WR_BURST,
      DONE
   } state_t;

endpackage

// File: rtl/pmem_burst_adaptor.sv
// Converts cache line read/write requests into BEATS-beat bursts on the memory port.
// Optional ADAPTOR_STATS_EN adds saturating completed-burst counters stat_rd_o/stat_wr_o.
module pmem_burst_adaptor
   import pmem_burst_pkg::*;
#(
   parameter int unsigned LINE_W = PMEM_LINE_W,
   parameter int unsigned BEAT_W = PMEM_BEAT_W,
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              line_read_i,
   input  logic              line_write_i,
   input  logic [ADDR_W-1:0] line_addr_i,
   input  logic [LINE_W-1:0] line_wdata_i,
   output logic [LINE_W-1:0] line_rdata_o,
   output logic              line_resp_o,
   output logic [ADDR_W-1:0] burst_addr_o,
   output logic              burst_read_o,
   output logic              burst_write_o,
   output logic [BEAT_W-1:0] burst_wdata_o,
   input  logic [BEAT_W-1:0] burst_rdata_i,
   input  logic              burst_resp_i
`ifdef ADAPTOR_STATS_EN
   ,
   output logic [31:0]       stat_rd_o,
   output logic [31:0]       stat_wr_o
`endif
);

   localparam int unsigned BEATS = LINE_W / BEAT_W;
   localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned OFF_W = $clog2(LINE_W / 8);
   localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(BEATS - 1);
   localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};

   state_t            r_state;
   state_t            w_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic [LINE_W-1:0] r_line;
   logic [LINE_W-1:0] r_wline;
   logic              w_last;

   assign w_last = burst_resp_i && (r_cnt == LAST_CNT);

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (line_write_i)     w_next = WR_BURST;
            else if (line_read_i) w_next = RD_BURST;
         end
         RD_BURST: if (w_last) w_next = DONE;
         WR_BURST: if (w_last) w_next = DONE;
         DONE:     w_next = IDLE;
         default:  w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_line  <= '0;
         r_wline <= '0;
      end else begin
         r_state <= w_next;
         unique case (r_state)
            IDLE: begin
               if (line_write_i || line_read_i) begin
                  r_addr <= line_addr_i & LINE_MASK;
                  r_cnt  <= '0;
               end
               if (line_write_i) r_wline <= line_wdata_i;
            end
            RD_BURST: begin
               if (burst_resp_i) begin
                  for (int unsigned b = 0; b < BEATS; b++) begin
                     if (r_cnt == CNT_W'(b)) r_line[b*BEAT_W +: BEAT_W] <= burst_rdata_i;
                  end
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            WR_BURST: if (burst_resp_i) r_cnt <= r_cnt + 1'b1;
            default: ;
         endcase
      end
   end

   assign burst_read_o  = (r_state == RD_BURST);
   assign burst_write_o = (r_state == WR_BURST);
   assign line_resp_o   = (r_state == DONE);
   assign burst_addr_o  = r_addr;
   assign line_rdata_o  = r_line;

   always_comb begin
      burst_wdata_o = '0;
      if (r_state == WR_BURST) begin
         for (int unsigned b = 0; b < BEATS; b++) begin
            if (r_cnt == CNT_W'(b)) burst_wdata_o = r_wline[b*BEAT_W +: BEAT_W];
         end
      end
   end

`ifdef ADAPTOR_STATS_EN
   logic        r_is_wr;
   logic [31:0] r_stat_rd;
   logic [31:0] r_stat_wr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_is_wr   <= 1'b0;
         r_stat_rd <= '0;
         r_stat_wr <= '0;
      end else begin
         if (r_state == IDLE) r_is_wr <= line_write_i;
         if (r_state == DONE) begin
            if (r_is_wr && (r_stat_wr != '1))       r_stat_wr <= r_stat_wr + 1'b1;
            else if (!r_is_wr && (r_stat_rd != '1)) r_stat_rd <= r_stat_rd + 1'b1;
         end
      end
   end

   assign stat_rd_o = r_stat_rd;
   assign stat_wr_o = r_stat_wr;
`endif

endmodule

// File: tb/tb_pmem_burst_adaptor.sv
// Self-checking bench for pmem_burst_adaptor: line-level transaction model with random gaps.
module tb_pmem_burst_adaptor;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         line_read_i = 1'b0;
   logic         line_write_i = 1'b0;
   logic [31:0]  line_addr_i = '0;
   logic [255:0] line_wdata_i = '0;
   logic [255:0] line_rdata_o;
   logic         line_resp_o;
   logic [31:0]  burst_addr_o;
   logic         burst_read_o;
   logic         burst_write_o;
   logic [63:0]  burst_wdata_o;
   logic [63:0]  burst_rdata_i = '0;
   logic         burst_resp_i = 1'b0;
`ifdef ADAPTOR_STATS_EN
   logic [31:0]  stat_rd_o;
   logic [31:0]  stat_wr_o;
`endif

   int unsigned checks = 0;
   int unsigned failures = 0;
   int unsigned n_rd = 0;
   int unsigned n_wr = 0;

   always #5 clk = ~clk;

   pmem_burst_adaptor #(.LINE_W(256), .BEAT_W(64), .ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .line_read_i(line_read_i), .line_write_i(line_write_i),
      .line_addr_i(line_addr_i), .line_wdata_i(line_wdata_i),
      .line_rdata_o(line_rdata_o), .line_resp_o(line_resp_o),
      .burst_addr_o(burst_addr_o), .burst_read_o(burst_read_o),
      .burst_write_o(burst_write_o), .burst_wdata_o(burst_wdata_o),
      .burst_rdata_i(burst_rdata_i), .burst_resp_i(burst_resp_i)
`ifdef ADAPTOR_STATS_EN
      , .stat_rd_o(stat_rd_o), .stat_wr_o(stat_wr_o)
`endif
   );

   // One full line transaction; the memory side is emulated beat by beat.
   task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [255:0] line, input int unsigned gap_fixed, input bit gap_rnd);
      int unsigned k, gaps, gap_left;
      bit          done, exp_cmd;
      k = 0; gaps = 0; done = 0;
      gap_left = gap_rnd ? $urandom_range(0, 2) : 0;
      line_read_i = rd; line_write_i = wr; line_addr_i = addr; line_wdata_i = line;
      burst_resp_i = 1'($urandom); burst_rdata_i = {2{$urandom}};
      for (int unsigned c = 0; c < 64 && !done; c++) begin
         if (c > 0) begin
            line_addr_i = $urandom;
            line_wdata_i = {8{$urandom}};
         end
         if (line_resp_o) begin
            checks++;
            if (c != 5 + gaps || k != 4) begin
               failures++;
               $display("FAIL resp_timing: got cycle=%0d beats=%0d, expected cycle=%0d beats=4", c, k, 5 + gaps);
            end
            if (!wr) begin
               checks++;
               if (line_rdata_o !== line) begin
                  failures++;
                  $display("FAIL read_line: got %h expected %h", line_rdata_o, line);
               end
               n_rd++;
            end else n_wr++;
            line_read_i = 0; line_write_i = 0; burst_resp_i = 1'($urandom);
            @(posedge clk); #1;
            checks++;
            if (line_resp_o !== 0 || burst_read_o !== 0 || burst_write_o !== 0) begin
               failures++;
               $display("FAIL post_done: got resp=%b rd=%b wr=%b expected 0 0 0",
                        line_resp_o, burst_read_o, burst_write_o);
            end
            done = 1;
         end else begin
            exp_cmd = (c >= 1);
            checks++;
            if (burst_read_o !== (exp_cmd && !wr) || burst_write_o !== (exp_cmd && wr)) begin
               failures++;
               $display("FAIL cmd c=%0d: got rd=%b wr=%b expected rd=%b wr=%b", c,
                        burst_read_o, burst_write_o, exp_cmd && !wr, exp_cmd && wr);
            end
            if (exp_cmd && k < 4) begin
               checks++;
               if (burst_addr_o !== {addr[31:5], 5'b0}) begin
                  failures++;
                  $display("FAIL burst_addr: got %h expected %h", burst_addr_o, {addr[31:5], 5'b0});
               end
               if (wr) begin
                  checks++;
                  if (burst_wdata_o !== line[k*64 +: 64]) begin
                     failures++;
                     $display("FAIL wdata beat%0d: got %h expected %h", k, burst_wdata_o, line[k*64 +: 64]);
                  end
               end
               if (gap_left > 0) begin
                  gap_left--; gaps++;
                  burst_resp_i = 0; burst_rdata_i = {2{$urandom}};
               end else begin
                  burst_resp_i = 1; burst_rdata_i = line[k*64 +: 64]; k++;
                  gap_left = gap_rnd ? $urandom_range(0, 2) : gap_fixed;
               end
            end else if (!exp_cmd) begin
               burst_resp_i = 1'($urandom);
            end else begin
               burst_resp_i = 0;
            end
            @(posedge clk); #1;
         end
      end
      burst_resp_i = 0;
      if (!done) begin
         checks++; failures++;
         $display("FAIL timeout: got no line_resp_o expected one within 64 cycles");
         line_read_i = 0; line_write_i = 0;
      end
   endtask

   task automatic test_reset();
      line_read_i = 1; line_write_i = 1; line_addr_i = 32'hFFFF_FFFF; burst_resp_i = 1;
      #12;
      checks++;
      if (burst_read_o !== 0 || burst_write_o !== 0 || line_resp_o !== 0 ||
          burst_addr_o !== '0 || line_rdata_o !== '0 || burst_wdata_o !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got rd=%b wr=%b resp=%b addr=%h expected all zero",
                  burst_read_o, burst_write_o, line_resp_o, burst_addr_o);
      end
      line_read_i = 0; line_write_i = 0; burst_resp_i = 0;
      @(posedge clk); #1;
      rst_n = 1;
      @(posedge clk); #1;
      checks++;
      if (burst_read_o !== 0 || burst_write_o !== 0 || line_resp_o !== 0) begin
         failures++;
         $display("FAIL idle_after_reset: got rd=%b wr=%b resp=%b expected 0 0 0",
                  burst_read_o, burst_write_o, line_resp_o);
      end
   endtask

   task automatic test_read_basic();
      run_txn(1, 0, 32'h0000_1234,
              {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 0, 0);
   endtask

   task automatic test_write_gaps();
      run_txn(0, 1, 32'h8000_0047,
              {64'hDDCC_BBAA_0000_0003, 64'hDDCC_BBAA_0000_0002,
               64'hDDCC_BBAA_0000_0001, 64'hDDCC_BBAA_0000_0000}, 2, 0);
   endtask

   task automatic test_both_high();
      run_txn(1, 1, $urandom, {8{$urandom}}, 1, 0);
   endtask

   task automatic test_reset_mid_burst();
      line_read_i = 1; line_write_i = 0; line_addr_i = 32'hABCD_EF40; burst_resp_i = 0;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         burst_resp_i = 1; burst_rdata_i = {2{$urandom}};
         @(posedge clk); #1;
      end
      burst_resp_i = 0;
      checks++;
      if (burst_read_o !== 1) begin
         failures++;
         $display("FAIL mid_burst_cmd: got rd=%b expected 1", burst_read_o);
      end
      rst_n = 0; #1;
      checks++;
      if (burst_read_o !== 0 || burst_write_o !== 0 || line_resp_o !== 0 ||
          burst_addr_o !== '0 || line_rdata_o !== '0) begin
         failures++;
         $display("FAIL async_reset: got rd=%b resp=%b addr=%h expected 0 0 0",
                  burst_read_o, line_resp_o, burst_addr_o);
      end
      line_read_i = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      n_rd = 0; n_wr = 0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (line_resp_o !== 0 || burst_read_o !== 0) begin
            failures++;
            $display("FAIL no_resp_after_reset: got resp=%b rd=%b expected 0 0", line_resp_o, burst_read_o);
         end
         @(posedge clk); #1;
      end
      run_txn(1, 0, $urandom, {8{$urandom}}, 0, 1);
   endtask

   task automatic test_back_to_back();
      run_txn(1, 0, 32'h1000_0020, {8{$urandom}}, 0, 0);
      run_txn(0, 1, 32'h2000_0040, {8{$urandom}}, 0, 0);
      run_txn(1, 0, 32'h3000_001F, {8{$urandom}}, 0, 1);
   endtask

   task automatic test_random();
      logic r, w;
      for (int i = 0; i < 20; i++) begin
         r = 1'($urandom); w = 1'($urandom);
         if (!r && !w) r = 1;
         run_txn(r, w, $urandom, {8{$urandom}}, 0, 1);
      end
   endtask

`ifdef ADAPTOR_STATS_EN
   task automatic test_stats();
      rst_n = 0; #1;
      checks++;
      if (stat_rd_o !== 0 || stat_wr_o !== 0) begin
         failures++;
         $display("FAIL stats_reset: got rd=%0d wr=%0d expected 0 0", stat_rd_o, stat_wr_o);
      end
      @(posedge clk); #1 rst_n = 1;
      @(posedge clk); #1;
      n_rd = 0; n_wr = 0;
      for (int i = 0; i < 5; i++) run_txn(i < 3, i >= 3, $urandom, {8{$urandom}}, 0, 1);
      checks++;
      if (stat_rd_o !== n_rd || stat_wr_o !== n_wr || n_rd != 3 || n_wr != 2) begin
         failures++;
         $display("FAIL stats_count: got rd=%0d wr=%0d expected 3 2", stat_rd_o, stat_wr_o);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_read_basic();
      test_write_gaps();
      test_both_high();
      test_reset_mid_burst();
      test_back_to_back();
      test_random();
`ifdef ADAPTOR_STATS_EN
      test_stats();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
